// File: rtl/oserdes_gen_pkg.sv
// oserdes_gen shared types and helpers.
// FSM state, counter sizing, width check.
package oserdes_gen_pkg;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  function automatic bit dw_legal(input int w);
    return (w == 2) || (w == 4) ||
           (w == 8) || (w == 16);
  endfunction

endpackage

// File: rtl/oserdes_gen_lane.sv
// One serial lane: word shifter, T hold,
// bit-order select and registered pins.
module oserdes_gen_lane
  import oserdes_gen_pkg::*;
#(
  parameter int   DW     = 8,
  parameter logic INIT   = 1'b0,
  parameter logic T_IDLE = 1'b1,
  parameter bit   MSBF   = 1'b0,
  parameter bit   BYPASS = 1'b0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          shift,
  input  logic          run,
  input  logic [DW-1:0] din,
  input  logic          tin,
  output logic          oq,
  output logic          tq
);

  logic [DW-1:0] sh;
  logic          tr;
  logic          head;

  assign head = MSBF ? sh[DW-1] : sh[0];

  // Shift the held word and register pins.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh <= '0;
      tr <= T_IDLE;
      oq <= INIT;
      tq <= T_IDLE;
    end else if (BYPASS) begin
      oq <= din[0];
      tq <= tin;
    end else begin
      if (load) begin
        sh <= din;
        tr <= tin;
      end else if (shift) begin
        sh <= MSBF ? {sh[DW-2:0], 1'b0}
                   : {1'b0, sh[DW-1:1]};
      end
      oq <= run ? head : INIT;
      tq <= run ? tr : T_IDLE;
    end
  end

endmodule

// File: rtl/oserdes_gen.sv
// Multi-lane output serializer with a
// one-word holding buffer and handshake.
module oserdes_gen
  import oserdes_gen_pkg::*;
#(
  parameter int    DATA_WIDTH = 8,
  parameter int    LANES      = 1,
  parameter logic  INIT       = 1'b0,
  parameter logic  T_IDLE     = 1'b1,
  parameter string MSB_FIRST  = "FALSE",
  parameter string D_BYPASS   = "FALSE"
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [LANES*DATA_WIDTH-1:0] D,
  input  logic [LANES-1:0]            T,
  input  logic                        D_VALID,
  output logic                        D_READY,
  output logic [LANES-1:0]            OQ,
  output logic [LANES-1:0]            T_OUT,
  output logic                        UNDERRUN
);

  localparam int DW   = DATA_WIDTH;
  localparam int CW   = cnt_w(DW);
  localparam bit MSBF = (MSB_FIRST == "TRUE");
  localparam bit BYP  = (D_BYPASS == "TRUE");

  if (!dw_legal(DW)) begin : g_bad_dw
    $error("oserdes_gen: bad DATA_WIDTH");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_ln
    $error("oserdes_gen: bad LANES");
  end

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  buf_full;
  logic                  full_nxt;
  logic                  rdy_q;
  logic                  ur_pend;
  logic                  ur_q;
  logic [LANES*DW-1:0]   buf_d;
  logic [LANES-1:0]      buf_t;
  logic                  last;
  logic                  accept;
  logic                  load;
  logic                  running;

  assign last    = (cnt == CW'(DW - 1));
  assign running = (state == S_RUN);
  assign accept  = D_VALID & rdy_q & ~BYP;
  assign load    = buf_full & (~running | last);

  // Buffer occupancy; a load always wins.
  always_comb begin
    full_nxt = buf_full;
    if (load) full_nxt = 1'b0;
    else if (accept) full_nxt = 1'b1;
  end

  // Control FSM, bit counter and buffer.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      buf_full <= 1'b0;
      rdy_q    <= 1'b0;
      ur_pend  <= 1'b0;
      ur_q     <= 1'b0;
      buf_d    <= '0;
      buf_t    <= '0;
    end else begin
      if (accept) begin
        buf_d <= D;
        buf_t <= T;
      end
      buf_full <= full_nxt;
      rdy_q    <= ~full_nxt;
      ur_q     <= ur_pend;
      ur_pend  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (buf_full) state <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (last && !buf_full) begin
            state   <= S_IDLE;
            ur_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign D_READY  = BYP ? 1'b1 : rdy_q;
  assign UNDERRUN = BYP ? 1'b0 : ur_q;

  for (genvar n = 0; n < LANES; n++) begin : g_lane
    oserdes_gen_lane #(
      .DW     (DW),
      .INIT   (INIT),
      .T_IDLE (T_IDLE),
      .MSBF   (MSBF),
      .BYPASS (BYP)
    ) u_lane (
      .CLK   (CLK),
      .RST   (RST),
      .load  (load),
      .shift (running),
      .run   (running),
      .din   (BYP ? D[n*DW +: DW]
                  : buf_d[n*DW +: DW]),
      .tin   (BYP ? T[n] : buf_t[n]),
      .oq    (OQ[n]),
      .tq    (T_OUT[n])
    );
  end

endmodule

// File: tb/tb_oserdes_gen.sv
// Randomized bench for oserdes_gen with a
// word-timeline reference model.
module tb_oserdes_gen;

  localparam int NC = 2600;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic v0, r0, u0;
  logic [15:0] d0;
  logic [1:0] t0, q0, to0;
  logic v1, r1, u1, t1, q1, to1;
  logic [3:0] d1;
  logic v2, r2, u2, t2, q2, to2;
  logic [1:0] d2;
  logic v3, r3, u3, t3, q3, to3;
  logic [7:0] d3;

  oserdes_gen #(.DATA_WIDTH(8), .LANES(2)) dut0 (
    .CLK(CLK), .RST(RST), .D(d0), .T(t0),
    .D_VALID(v0), .D_READY(r0), .OQ(q0),
    .T_OUT(to0), .UNDERRUN(u0));

  oserdes_gen #(.DATA_WIDTH(4), .LANES(1),
    .MSB_FIRST("TRUE")) dut1 (
    .CLK(CLK), .RST(RST), .D(d1), .T(t1),
    .D_VALID(v1), .D_READY(r1), .OQ(q1),
    .T_OUT(to1), .UNDERRUN(u1));

  oserdes_gen #(.DATA_WIDTH(2), .LANES(1)) dut2 (
    .CLK(CLK), .RST(RST), .D(d2), .T(t2),
    .D_VALID(v2), .D_READY(r2), .OQ(q2),
    .T_OUT(to2), .UNDERRUN(u2));

  oserdes_gen #(.DATA_WIDTH(8), .LANES(1),
    .D_BYPASS("TRUE")) dut3 (
    .CLK(CLK), .RST(RST), .D(d3), .T(t3),
    .D_VALID(v3), .D_READY(r3), .OQ(q3),
    .T_OUT(to3), .UNDERRUN(u3));

  int vec = 0;
  int mis = 0;
  int cyc = 0;
  int hs2 = 0;
  logic pr2 = 1'b0;

  // expected per cycle, indexed [dut][cycle]
  logic [1:0] eq [3][NC];
  logic [1:0] et [3][NC];
  bit eu [3][NC];
  bit er [3][NC];
  int lastE [3];
  bit hasp [3];
  bit acc [3];
  int cdw [3] = '{8, 4, 2};
  bit cmsb [3] = '{1'b0, 1'b1, 1'b0};
  int cln [3] = '{2, 1, 1};
  logic e3q, e3t;

  logic [1:0] hq0 [NC];
  logic [1:0] hto0 [NC];
  logic hu0 [NC];
  logic hq1 [NC];
  logic hu1 [NC];
  logic hu2 [NC];

  task automatic chk(input string nm,
                     input logic [1:0] act,
                     input logic [1:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s cyc=%0d got=%b exp=%b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string nm,
                       input int act,
                       input int exp);
    vec++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s got=%0d exp=%0d",
               nm, act, exp);
    end
  endtask

  function automatic bit vin(input int d);
    case (d)
      0: return v0;
      1: return v1;
      default: return v2;
    endcase
  endfunction

  function automatic logic [31:0] win(input int d);
    case (d)
      0: return {16'b0, d0};
      1: return {28'b0, d1};
      default: return {30'b0, d2};
    endcase
  endfunction

  function automatic logic [1:0] tin(input int d);
    case (d)
      0: return t0;
      1: return {1'b0, t1};
      default: return {1'b0, t2};
    endcase
  endfunction

  task automatic wipe(input int d, input int t);
    for (int tt = t; tt < NC; tt++) begin
      eq[d][tt] = 2'b00;
      et[d][tt] = 2'b11;
      eu[d][tt] = 1'b0;
      er[d][tt] = 1'b1;
    end
    er[d][t] = 1'b0;
    lastE[d] = -100;
    hasp[d]  = 1'b0;
  endtask

  // word accepted at edge a: place its bits
  task automatic sched(input int d, input int a,
                       input logic [31:0] w,
                       input logic [1:0] tv);
    int dw, st, tt, idx;
    dw = cdw[d];
    st = a + 2;
    if (lastE[d] + 1 > st) st = lastE[d] + 1;
    if (hasp[d] && st == lastE[d] + 1)
      eu[d][st] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      tt = st + i;
      if (tt < NC)
        for (int l = 0; l < cln[d]; l++) begin
          idx = l * dw + (cmsb[d] ? dw - 1 - i : i);
          eq[d][tt][l] = w[idx];
          et[d][tt][l] = tv[l];
        end
    end
    lastE[d] = st + dw - 1;
    if (lastE[d] + 1 < NC) eu[d][lastE[d] + 1] = 1'b1;
    hasp[d] = 1'b1;
    for (tt = a; tt <= st - 2; tt++) er[d][tt] = 1'b0;
  endtask

  // model update at each edge, compare after it
  initial begin
    int t;
    for (int d = 0; d < 3; d++) wipe(d, 0);
    forever begin
      @(posedge CLK);
      cyc++;
      t = cyc;
      for (int d = 0; d < 3; d++) begin
        acc[d] = 1'b0;
        if (RST) wipe(d, t);
        else if (vin(d) && er[d][t-1]) begin
          acc[d] = 1'b1;
          sched(d, t, win(d), tin(d));
        end
      end
      if (v2 && pr2 && !RST) hs2++;
      e3q = RST ? 1'b0 : d3[0];
      e3t = RST ? 1'b1 : t3;
      #1;
      pr2 = r2;
      if (t < NC) begin
        hq0[t] = q0; hto0[t] = to0; hu0[t] = u0;
        hq1[t] = q1; hu1[t] = u1; hu2[t] = u2;
        chk("oq0", q0, eq[0][t]);
        chk("tout0", to0, et[0][t]);
        chk("ur0", {1'b0, u0}, {1'b0, eu[0][t]});
        chk("rdy0", {1'b0, r0}, {1'b0, er[0][t]});
        chk("oq1", {1'b0, q1}, {1'b0, eq[1][t][0]});
        chk("tout1", {1'b0, to1}, {1'b0, et[1][t][0]});
        chk("ur1", {1'b0, u1}, {1'b0, eu[1][t]});
        chk("rdy1", {1'b0, r1}, {1'b0, er[1][t]});
        chk("oq2", {1'b0, q2}, {1'b0, eq[2][t][0]});
        chk("tout2", {1'b0, to2}, {1'b0, et[2][t][0]});
        chk("ur2", {1'b0, u2}, {1'b0, eu[2][t]});
        chk("rdy2", {1'b0, r2}, {1'b0, er[2][t]});
        chk("byp_oq", {1'b0, q3}, {1'b0, e3q});
        chk("byp_t", {1'b0, to3}, {1'b0, e3t});
        chk("byp_rdy", {1'b0, r3}, 2'b01);
        chk("byp_ur", {1'b0, u3}, 2'b00);
      end
    end
  end

  // bypass lane: bit 0 toggles every cycle
  initial begin
    logic tog;
    tog = 1'b0;
    d3 = '0; t3 = 1'b0; v3 = 1'b0;
    forever begin
      @(negedge CLK);
      d3 = 8'($urandom);
      d3[0] = tog;
      tog = ~tog;
      t3 = 1'($urandom);
      v3 = 1'($urandom);
    end
  end

  task automatic edge2();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int a, b, c, f, n, g, h0, nur;
    logic [7:0] pa, pc;
    v0 = 0; d0 = '0; t0 = '0;
    v1 = 0; d1 = '0; t1 = 0;
    v2 = 0; d2 = '0; t2 = 0;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    edge2();
    chk("rdy_first_edge", {1'b0, r0}, 2'b01);

    // A5 on lane0, FF on lane1; C then 3 on dut1
    @(negedge CLK);
    v0 = 1; d0 = {8'hFF, 8'hA5}; t0 = 2'b10;
    v1 = 1; d1 = 4'hC; t1 = 0;
    edge2();
    a = cyc;
    @(negedge CLK);
    v0 = 0; d1 = 4'h3;
    @(negedge CLK);
    @(negedge CLK);
    v1 = 0;
    repeat (14) @(negedge CLK);
    pa = 8'hA5;
    pc = 8'b11000011;
    for (int i = 0; i < 8; i++) begin
      chk("a5_bit", {1'b0, hq0[a+2+i][0]},
          {1'b0, pa[i]});
      chk("ff_bit", {1'b0, hq0[a+2+i][1]}, 2'b01);
      chk("t_lanes", hto0[a+2+i], 2'b10);
      chk("c3_bit", {1'b0, hq1[a+2+i]},
          {1'b0, pc[7-i]});
      chk("c3_no_ur", {1'b0, hu1[a+2+i]}, 2'b00);
    end
    chk("a5_idle", hq0[a+10], 2'b00);
    chk("a5_tidle", hto0[a+10], 2'b11);
    chk("a5_ur_pre", {1'b0, hu0[a+9]}, 2'b00);
    chk("a5_ur", {1'b0, hu0[a+10]}, 2'b01);
    chk("a5_ur_post", {1'b0, hu0[a+11]}, 2'b00);
    chk("c3_ur", {1'b0, hu1[a+10]}, 2'b01);

    // reset at bit 3 with a second word queued
    @(negedge CLK);
    v0 = 1; d0 = {8'h00, 8'h5A}; t0 = 2'b00;
    edge2();
    b = cyc;
    @(negedge CLK);
    d0 = {8'h00, 8'hC3};
    @(negedge CLK);
    @(negedge CLK);
    v0 = 0;
    while (cyc < b + 5) edge2();
    @(negedge CLK);
    chk("bit3_live", {1'b0, hq0[b+5][0]}, 2'b01);
    RST = 1'b1;
    #1;
    chk("rst_oq", q0, 2'b00);
    chk("rst_t", to0, 2'b11);
    chk("rst_ur", {1'b0, u0}, 2'b00);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    edge2();
    @(negedge CLK);
    v0 = 1; d0 = {8'h0F, 8'h81}; t0 = 2'b01;
    edge2();
    c = cyc;
    @(negedge CLK);
    v0 = 0;
    repeat (12) @(negedge CLK);
    chk("post_b0", hq0[c+2], 2'b11);
    chk("post_b1", hq0[c+3], 2'b10);
    chk("post_t", hto0[c+2], 2'b01);
    nur = 0;
    for (int k = b + 5; k <= c + 1; k++)
      nur += int'(hu0[k]);
    chk_i("rst_no_ur", nur, 0);

    // ten back-to-back words on the 2-bit dut
    h0 = hs2;
    @(negedge CLK);
    v2 = 1; d2 = 2'($urandom); t2 = 1'($urandom);
    n = 0; g = 0; f = cyc + 1;
    while (n < 10 && g < 200) begin
      @(negedge CLK);
      g++;
      if (acc[2]) begin
        n++;
        if (n == 10) v2 = 0;
        else begin
          d2 = 2'($urandom);
          t2 = 1'($urandom);
        end
      end
    end
    chk_i("burst_bound", n, 10);
    repeat (10) @(negedge CLK);
    chk_i("burst_hs", hs2 - h0, 10);
    nur = 0;
    for (int k = f; k <= cyc; k++)
      nur += int'(hu2[k]);
    chk_i("burst_ur", nur, 1);

    // random traffic with sparse resets
    repeat (1500) begin
      @(negedge CLK);
      v0 = ($urandom % 3) != 0;
      d0 = 16'($urandom); t0 = 2'($urandom);
      v1 = ($urandom % 3) != 0;
      d1 = 4'($urandom); t1 = 1'($urandom);
      v2 = ($urandom % 4) != 0;
      d2 = 2'($urandom); t2 = 1'($urandom);
      RST = ($urandom % 300) == 0;
    end
    @(negedge CLK);
    RST = 0; v0 = 0; v1 = 0; v2 = 0;
    repeat (30) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec, mis);
    $finish;
  end

endmodule

// File: doc/oserdes_gen.md
OSERDES_GEN -- requirements
Module: oserdes_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per parallel word per lane; legal values 2, 4, 8 and 16; any other value is an elaboration error.
REQ-002 SHALL have parameter LANES, default 1, meaning the number of independent serial lanes (1..16).
REQ-003 SHALL have parameter INIT, default 1'b0, meaning the OQ level after reset and while idle.
REQ-004 SHALL have parameter T_IDLE, default 1'b1, meaning the T_OUT level after reset and while idle (1 = high-Z).
REQ-005 SHALL have parameter MSB_FIRST, default "FALSE"; "FALSE" sends bit 0 first, "TRUE" sends bit DATA_WIDTH-1 first.
REQ-006 SHALL have parameter D_BYPASS, default "FALSE"; "TRUE" selects the bypass mode of REQ-018.
REQ-007 SHALL have port CLK, input, 1 bit: the single serial clock; all state changes on its rising edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port D, input, LANES*DATA_WIDTH bits: parallel words; lane n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port T, input, LANES bits: per-lane tristate control for the presented word.
REQ-011 SHALL have port D_VALID, input, 1 bit: D and T are presented for transfer.
REQ-012 SHALL have port D_READY, output, 1 bit: the block accepts D and T.
REQ-013 SHALL have port OQ, output, LANES bits: serial data, one bit per CLK cycle.
REQ-014 SHALL have port T_OUT, output, LANES bits: serialized tristate control, aligned with OQ.
REQ-015 SHALL have port UNDERRUN, output, 1 bit: single-cycle pulse when a burst ends because no next word is buffered.

Function
REQ-016 SHALL transfer a word on a rising CLK edge where D_VALID=1 and D_READY=1 into a one-entry holding buffer; D_READY SHALL be a registered signal equal to the inverse of the buffer-full flag.
REQ-017 SHALL implement FSM IDLE->RUN on any edge in IDLE with the buffer full, RUN->RUN at the last bit (counter = DATA_WIDTH-1) with the buffer full, and RUN->IDLE at the last bit with the buffer empty.
REQ-018 SHALL, when D_BYPASS="TRUE", hold D_READY=1 constantly, register lane bit 0 of D to OQ and T to T_OUT every cycle, ignore D_VALID, and never assert UNDERRUN.
REQ-019 SHALL load all lane shifters from the buffer and clear the buffer on the same edge; the first bit SHALL appear on OQ two edges after the accepting edge.
REQ-020 SHALL shift one bit per cycle with a shared counter of width $clog2(DATA_WIDTH) that wraps from DATA_WIDTH-1 to 0.
REQ-021 SHALL hold T_OUT[n] at the T[n] of the word being shifted for all DATA_WIDTH bits.
REQ-022 SHALL, when back-to-back words are offered with D_VALID held high, produce gap-free output: the first bit of word k+1 follows the last bit of word k on the next cycle.
REQ-023 SHALL drive OQ=INIT and T_OUT=T_IDLE on all lanes in IDLE.
REQ-024 SHALL pulse UNDERRUN for exactly the first IDLE cycle after a RUN->IDLE transition.
REQ-025 SHALL give buffer refill priority over a new acceptance on the same edge; because D_READY is registered, no acceptance occurs while the buffer is full.

Reset
REQ-026 SHALL, while RST=1 and asynchronously, set the FSM to IDLE, counter=0, buffer empty, D_READY=0, OQ=INIT, T_OUT=T_IDLE, UNDERRUN=0.
REQ-027 SHALL raise D_READY on the first rising CLK edge after RST deasserts.
REQ-028 SHALL, on a reset during RUN, discard the partial word and the buffered word without asserting UNDERRUN.

Structure
REQ-029 SHALL place the FSM state enum, the counter-width function and the legal-DATA_WIDTH check in package oserdes_gen_pkg.
REQ-030 SHALL instantiate sub-module oserdes_gen_lane once per lane, containing the shift register, the T register and the bit-order select; the FSM, counter and buffer flag SHALL stay in the top level.

Verification
REQ-031 SHALL cover: DATA_WIDTH=8, LANES=1, D=8'hA5 accepted once -> OQ 1,0,1,0,0,1,0,1 starting on the 2nd edge after acceptance, then INIT and a single UNDERRUN pulse.
REQ-032 SHALL cover: MSB_FIRST="TRUE", DATA_WIDTH=4, words 4'hC then 4'h3 back-to-back -> OQ 1,1,0,0,0,0,1,1 with no gap and no UNDERRUN between the words.
REQ-033 SHALL cover: LANES=2, T=2'b10, D={8'hFF,8'h00} -> lane1 T_OUT=1 and lane0 T_OUT=0 for all 8 bits, then both return to T_IDLE.
REQ-034 SHALL cover: RST asserted at bit 3 of a word with a second word buffered -> OQ=INIT immediately, no UNDERRUN, and after release a new word serializes correctly.
REQ-035 SHALL cover: D_VALID held high for 10 words at DATA_WIDTH=2 -> 20 contiguous output bits and exactly 10 handshakes.
REQ-036 SHALL cover: D_BYPASS="TRUE", D lane bit 0 toggling each cycle -> OQ follows with one-cycle latency and D_READY stays 1.
